aes128_enc_iter: RTL
====================

# aes128_enc_iter

Iterative AES-128 encryption core, the forward-direction counterpart of the AES decryption datapath. It takes one 128-bit plaintext block and one 128-bit cipher key per transaction. It performs one full round per clock, generating round keys on the fly, and returns the ciphertext through a valid/ready output port. It sits beside the decryption core in `aes_core` and is built from the same submodule library.

## Interface
- No parameters; key size fixed at 128 bits, Nr = 10.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  plaintext/key offered.
- `in_ready`  out  1  core idle and able to accept.
- `plaintext`  in  128  bits [127:120] = byte 0 (FIPS-197 order).
- `key`  in  128  cipher key, same byte order.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  downstream accepts ciphertext.
- `ciphertext`  out  128  result, same byte order.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: state_reg <= plaintext ^ key (initial AddRoundKey), rk_reg <= key, round <= 1, rcon <= 8'h01, go RUN.
- RUN, once per cycle:
  - next_rk = KeyExpand(rk_reg, rcon): RotWord, SubWord on word 3, XOR rcon into the top byte, then chain the XOR through words 0..3.
  - state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_rk for rounds 1..9.
  - Round 10 skips MixColumns.
  - rk_reg <= next_rk, round <= round+1.
  - rcon <= xtime(rcon), giving 01,02,04,08,10,20,40,80,1b,36.
  - After the round-10 update, go DONE.
- DONE:
  - out_valid=1 and ciphertext=state_reg, held stable until out_ready.
  - On out_ready, go IDLE.
- SubBytes and SubWord use 20 instances of the existing combinational forward S-box submodule `aes_sbox` (8-bit in/out): 16 for the state, 4 for the key schedule.
- xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00); all GF(2^8) arithmetic mod x^8+x^4+x^3+x+1.
- `round` is a 4-bit counter (values 1..10). It never wraps: any value outside 1..10 in RUN forces a return to IDLE.
- In IDLE, in_valid is ignored only when in_ready=0. That cannot happen, so every in_valid in IDLE is accepted.
- in_valid during RUN or DONE is ignored. plaintext and key are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, ciphertext=128'h0 (state_reg, rk_reg and round all cleared), rcon=8'h01.
- Accept edge = the cycle with in_valid&in_ready. in_ready drops the next cycle.
- Rounds 1..10 occupy the 10 following edges.
- out_valid rises 11 cycles after the accept cycle.
- Handshake completes in the cycle with out_valid&out_ready. in_ready is high the next cycle, so no overlap between output and new input.
- Minimum issue interval is 12 cycles (out_ready tied high).
- out_ready held low: out_valid and ciphertext stay constant indefinitely.
- rst asserted mid-RUN or in DONE: everything returns to reset values immediately (asynchronous). The in-flight block is discarded with no partial output.
- out_valid never asserts without a preceding accept since the last reset.

## Test plan
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff → ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept.
- FIPS-197 Appendix B: key=2b7e151628aed2a6abf7158809cf4f3c, plaintext=3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. Also check the internal round-10 key = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure:
  - hold out_ready=0 for 20 cycles after out_valid → ciphertext stable, in_ready=0 throughout;
  - a new in_valid with different data during the stall is ignored;
  - after release, the first result is still the C.1 value.
- Back-to-back: in_valid and out_ready held high with two C.1/B vectors queued → accepts spaced 12 cycles, both results correct and in order.
- Input churn: change plaintext/key every cycle during RUN → result matches the values present at the accept edge only.
- Reset mid-operation: assert rst at round 5 → out_valid=0, in_ready=1, ciphertext=0 immediately. A subsequent C.1 transaction completes correctly.

Source files
------------

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one full round per clock, with round
// keys expanded on the fly from the cipher key captured at accept time.
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high; the producer holds valid and data stable until that edge.
// The input side is accepted only in IDLE, and the output side is offered
// only in DONE, so a result and a new block never overlap.

// Combinational forward S-box: multiplicative inverse in GF(2^8) followed
// by the FIPS-197 affine transform.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // a^254 = product of a^(2^i) for i = 1..7; zero maps to zero.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv;

    // Inverse then affine map (b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63).
    always_comb begin
        inv = ginv(a);
        s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes128_enc_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm;
    logic [127:0] state_reg;
    logic [127:0] rk_reg;
    logic [3:0]   round;
    logic [7:0]   rcon;

    logic [127:0] sb;       // SubBytes(state_reg)
    logic [127:0] sr;       // ShiftRows(sb)
    logic [127:0] mc;       // MixColumns(sr)
    logic [31:0]  rot_w3;   // RotWord(w3)
    logic [31:0]  sub_w3;   // SubWord(RotWord(w3))
    logic [127:0] next_rk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte n of the state lives at bits [127-8n -: 8]; n = 4*column + row.
    genvar gi, gc, gr;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sb
            aes_sbox u_sbox (.a(state_reg[127-8*gi -: 8]), .s(sb[127-8*gi -: 8]));
        end
        for (gc = 0; gc < 4; gc++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                assign sr[127-8*(gr+4*gc) -: 8] = sb[127-8*(gr+4*((gc+gr)%4)) -: 8];
            end
            assign mc[127-32*gc -: 32] = mix_col(sr[127-32*gc -: 32]);
        end
        for (gi = 0; gi < 4; gi++) begin : g_kw
            aes_sbox u_sbox (.a(rot_w3[31-8*gi -: 8]), .s(sub_w3[31-8*gi -: 8]));
        end
    endgenerate

    assign rot_w3 = {rk_reg[23:0], rk_reg[31:24]};

    // Key schedule step: temp = SubWord(RotWord(w3)) ^ rcon, chained through w0..w3.
    always_comb begin
        next_rk[127:96] = rk_reg[127:96] ^ sub_w3 ^ {rcon, 24'h0};
        next_rk[95:64]  = rk_reg[95:64]  ^ next_rk[127:96];
        next_rk[63:32]  = rk_reg[63:32]  ^ next_rk[95:64];
        next_rk[31:0]   = rk_reg[31:0]   ^ next_rk[63:32];
    end

    assign ciphertext = state_reg;

    // Control FSM with registered handshake outputs and the round datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            state_reg <= 128'h0;
            rk_reg    <= 128'h0;
            round     <= 4'd0;
            rcon      <= 8'h01;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= plaintext ^ key;
                        rk_reg    <= key;
                        round     <= 4'd1;
                        rcon      <= 8'h01;
                        fsm       <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (round == 4'd0 || round > 4'd10) begin
                        // Corrupted round counter: abandon the block.
                        fsm      <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state_reg <= ((round == 4'd10) ? sr : mc) ^ next_rk;
                        rk_reg    <= next_rk;
                        round     <= round + 4'd1;
                        rcon      <= xtime(rcon);
                        if (round == 4'd10) begin
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
